// File: rtl/quadra_pipe_pkg.sv
// Shared widths, payload bundles and result helpers for the quadratic pipe.
package quadra_pipe_pkg;

  localparam int OP_MAX   = 32;
  localparam int PROD_MAX = 64;
  localparam int TAG_MAX  = 16;

  // Operands are carried sign-extended to a fixed width.
  typedef struct packed {
    logic [OP_MAX-1:0]  x2;
    logic [OP_MAX-1:0]  a;
    logic [OP_MAX-1:0]  b;
    logic [OP_MAX-1:0]  c;
    logic [TAG_MAX-1:0] tag;
  } s1_pay_t;

  typedef struct packed {
    logic [PROD_MAX-1:0] a;
    logic [PROD_MAX-1:0] pb;
    logic [PROD_MAX-1:0] pc;
    logic [TAG_MAX-1:0]  tag;
  } s2_pay_t;

  function automatic int calc_sw(
    input int a_w,
    input int b_w,
    input int c_w,
    input int x2_w
  );
    int m;
    m = a_w;
    if (b_w + x2_w > m) m = b_w + x2_w;
    if (c_w + 2*x2_w + 1 > m) m = c_w + 2*x2_w + 1;
    return m + 2;
  endfunction

  function automatic logic signed [63:0] y_max(input int yw);
    return (64'sd1 <<< (yw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] y_min(input int yw);
    return -(64'sd1 <<< (yw - 1));
  endfunction

  function automatic logic sum_ovf(
    input logic signed [63:0] s,
    input int                 yw
  );
    return (s > y_max(yw)) || (s < y_min(yw));
  endfunction

  function automatic logic signed [63:0] sat_y(
    input logic signed [63:0] s,
    input int                 yw,
    input int                 sat
  );
    if (sat != 0 && s > y_max(yw)) return y_max(yw);
    if (sat != 0 && s < y_min(yw)) return y_min(yw);
    return s;
  endfunction

endpackage

// File: rtl/quadra_pipe_square.sv
// Registered signed square with valid pass-through; result is unsigned.
module pipe_square #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_valid,
  input  logic signed [W-1:0] i_x,
  output logic           o_valid,
  output logic [2*W-1:0] o_sq
);

  // (-2^(W-1))^2 = 2^(2W-2) still fits 2W bits.
  logic signed [2*W-1:0] w_p;
  logic                  r_valid;
  logic [2*W-1:0]        r_sq;

  assign w_p = i_x * i_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= 1'b0;
    else if (i_en) r_valid <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (i_en && i_valid) r_sq <= $unsigned(w_p);
  end

  assign o_valid = r_valid;
  assign o_sq    = r_sq;

endmodule

// File: rtl/quadra_pipe.sv
// Three-stage y = a + b*x2 + c*x2^2 with valid/ready and saturation.
module quadra_pipe
  import quadra_pipe_pkg::*;
#(
  parameter int X2_W  = 8,
  parameter int A_W   = 16,
  parameter int B_W   = 12,
  parameter int C_W   = 12,
  parameter int Y_W   = 16,
  parameter int TAG_W = 4,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [X2_W-1:0]  in_x2,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic signed [C_W-1:0]   in_c,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [Y_W-1:0]   out_y,
  output logic                    out_ovf,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SW   = calc_sw(A_W, B_W, C_W, X2_W);
  localparam int SQ_W = 2 * X2_W;
  localparam int PB_W = B_W + X2_W;
  localparam int PC_W = C_W + 2*X2_W + 1;

  logic                   w_s1_valid;
  logic [SQ_W-1:0]        w_sq;
  s1_pay_t                r_s1;
  logic                   r_s2_valid;
  s2_pay_t                r_s2;
  logic                   r_out_valid;
  logic signed [Y_W-1:0]  r_out_y;
  logic                   r_out_ovf;
  logic [TAG_W-1:0]       r_out_tag;

  logic                   w_s3_ready;
  logic                   w_s2_ready;
  logic                   w_s1_adv;
  logic signed [PB_W-1:0] w_pb;
  logic signed [PC_W-1:0] w_pc;
  logic signed [SW-1:0]   w_sum;
  logic signed [63:0]     w_sum64;

  // Ready ripples back combinationally so a full pipe still streams.
  assign w_s3_ready = !r_out_valid || out_ready;
  assign w_s2_ready = !r_s2_valid || w_s3_ready;
  assign w_s1_adv   = w_s1_valid && w_s2_ready;
  assign in_ready   = !w_s1_valid || w_s1_adv;

  pipe_square #(
    .W (X2_W)
  ) u_sq (
    .clk     (clk),
    .rst     (rst),
    .i_en    (in_ready),
    .i_valid (in_valid),
    .i_x     (in_x2),
    .o_valid (w_s1_valid),
    .o_sq    (w_sq)
  );

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      r_s1.x2  <= OP_MAX'(in_x2);
      r_s1.a   <= OP_MAX'(in_a);
      r_s1.b   <= OP_MAX'(in_b);
      r_s1.c   <= OP_MAX'(in_c);
      r_s1.tag <= TAG_MAX'(in_tag);
    end
  end

  assign w_pb = PB_W'($signed(r_s1.b) * $signed(r_s1.x2));
  assign w_pc = PC_W'($signed(r_s1.c) * $signed({1'b0, w_sq}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s2_valid <= 1'b0;
    else if (w_s2_ready) r_s2_valid <= w_s1_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv) begin
      r_s2.a   <= PROD_MAX'($signed(r_s1.a));
      r_s2.pb  <= PROD_MAX'(w_pb);
      r_s2.pc  <= PROD_MAX'(w_pc);
      r_s2.tag <= r_s1.tag;
    end
  end

  assign w_sum = SW'($signed(r_s2.a)
               + $signed(r_s2.pb)
               + $signed(r_s2.pc));
  assign w_sum64 = 64'(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_ovf   <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_s3_ready) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_y   <= Y_W'(sat_y(w_sum64, Y_W, SAT));
        r_out_ovf <= sum_ovf(w_sum64, Y_W);
        r_out_tag <= TAG_W'(r_s2.tag);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_ovf   = r_out_ovf;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_quadra_pipe.sv
// Bench for quadra_pipe: vector table, backpressure, random stream, reset.
module tb_quadra_pipe;

  localparam int Y_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic signed [7:0]  in_x2;
  logic signed [15:0] in_a;
  logic signed [11:0] in_b, in_c;
  logic [3:0]         in_tag;
  logic               in_ready, out_valid, out_ovf;
  logic signed [15:0] out_y;
  logic [3:0]         out_tag;
  logic               in_ready_w, out_valid_w, out_ovf_w;
  logic signed [15:0] out_y_w;
  logic [3:0]         out_tag_w;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int x2, a, b, c, y, ovf, yw;
  } vec_t;

  typedef struct {
    longint y, ovf, yw;
    int     tag;
  } exp_t;

  vec_t vecs[10];
  exp_t q[$];

  always #5 clk = ~clk;

  quadra_pipe #(.SAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x2(in_x2), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  quadra_pipe #(.SAT(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_x2(in_x2), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_tag(in_tag),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_y(out_y_w), .out_ovf(out_ovf_w), .out_tag(out_tag_w)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic exp_t model(input longint x2, input longint a,
                                 input longint b, input longint c,
                                 input int tag);
    exp_t e;
    longint s, hi, lo, m, w;
    m  = 64'sd1 << Y_W;
    hi = (64'sd1 << (Y_W - 1)) - 1;
    lo = -(64'sd1 << (Y_W - 1));
    s  = a + b * x2 + c * x2 * x2;
    e.ovf = (s > hi || s < lo) ? 1 : 0;
    e.y   = (s > hi) ? hi : (s < lo) ? lo : s;
    w = ((s % m) + m) % m;
    if (w > hi) w = w - m;
    e.yw  = w;
    e.tag = tag;
    return e;
  endfunction

  task automatic drive_rand();
    in_x2  = 8'($urandom);
    if ($urandom_range(0, 7) == 0) in_x2 = -8'sd128;
    in_a   = 16'($urandom);
    in_b   = 12'($urandom);
    in_c   = 12'($urandom);
    in_tag = 4'($urandom);
  endtask

  // Called at posedge+1 with inputs driven; returns at next posedge+1.
  task automatic step(output bit acc, output bit ret);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    ret = out_valid && out_ready;
    if (ret) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_out: got y=%0d with nothing pending",
                 out_y);
      end else begin
        e = q.pop_front();
        chk("stream_y", out_y, e.y);
        chk("stream_ovf", out_ovf, e.ovf);
        chk("stream_tag", out_tag, e.tag);
        chk("stream_y_wrap", out_y_w, e.yw);
        chk("stream_ovf_wrap", out_ovf_w, e.ovf);
      end
    end
    if (acc) q.push_back(model(in_x2, in_a, in_b, in_c, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    in_x2  = 8'(v.x2);
    in_a   = 16'(v.a);
    in_b   = 12'(v.b);
    in_c   = 12'(v.c);
    in_tag = 4'(idx + 1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("vec_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("vec_latency", lat, 3);
    chk("vec_y", out_y, v.y);
    chk("vec_ovf", out_ovf, v.ovf);
    chk("vec_tag", out_tag, idx + 1);
    chk("vec_y_wrap", out_y_w, v.yw);
    chk("vec_ovf_wrap", out_ovf_w, v.ovf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc, ret;
    int k, rets, sent, cyc;

    vecs[0] = '{3, 100, 5, 2, 133, 0, 133};
    vecs[1] = '{-4, 0, 10, 1, -24, 0, -24};
    vecs[2] = '{-128, 0, 0, 1, 16384, 0, 16384};
    vecs[3] = '{-128, 32767, 0, 2047, 32767, 1, 16383};
    vecs[4] = '{-128, 32767, 0, -2048, -32768, 1, 32767};
    vecs[5] = '{0, 32767, 0, 0, 32767, 0, 32767};
    vecs[6] = '{1, 32767, 1, 0, 32767, 1, -32768};
    vecs[7] = '{0, -32768, 0, 0, -32768, 0, -32768};
    vecs[8] = '{1, -32768, -1, 0, -32768, 1, 32767};
    vecs[9] = '{127, -32768, -2048, -2048, -32768, 1, -32768};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x2 = '0; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_valid_wrap", out_valid_w, 0);
    #6;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Backpressure: only three fit, then the stall releases in order.
    out_ready = 1'b0;
    k = 0;
    drive_rand();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(acc, ret);
      if (acc) begin
        k++;
        drive_rand();
      end
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_full_accepts", in_ready, 1);
    rets = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 5);
      step(acc, ret);
      if (acc) begin
        k++;
        drive_rand();
      end
      if (ret) rets++;
    end
    in_valid = 1'b0;
    chk("bp_accepted_total", k, 5);
    chk("bp_retired", rets, 5);
    chk("bp_queue_empty", q.size(), 0);

    // Random stream with random stalls on both sides.
    sent = 0;
    rets = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (sent < 100 && cyc < 3000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        drive_rand();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc, ret);
      cyc++;
      if (ret) rets++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
        if (sent < 100 && $urandom_range(0, 1) == 1) begin
          drive_rand();
          in_valid = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin
      step(acc, ret);
      if (ret) rets++;
      cyc++;
    end
    chk("stream_sent", sent, 100);
    chk("stream_retired", rets, 100);
    chk("stream_drained", q.size(), 0);

    // Reset with a full pipe: everything in flight is discarded.
    out_ready = 1'b0;
    k = 0;
    drive_rand();
    in_valid = 1'b1;
    cyc = 0;
    while (k < 3 && cyc < 10) begin
      step(acc, ret);
      if (acc) begin
        k++;
        drive_rand();
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("mid_accepted", k, 3);
    chk("mid_out_valid_before", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_valid_wrap", out_valid_w, 0);
    chk("mid_rst_out_y", out_y, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_post_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("mid_no_stale", out_valid, 0);
      step(acc, ret);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quadra_pipe.md
Name: quadra_pipe

Overview:
- Parametrised, pipelined successor of the combinational quadratic evaluator. Computes y = a + b*x2 + c*x2^2 on signed operands.
- Adds configurable operand widths, a 3-stage pipeline, a valid/ready handshake with full backpressure, and an optional saturating output with a per-sample overflow flag.
- A user tag travels with each sample so downstream piecewise-approximation logic can match results to segments.

Parameters:
- X2_W, 8, signed x2 width
- A_W, 16, signed a width
- B_W, 12, signed b width
- C_W, 12, signed c width
- Y_W, 16, signed y width
- TAG_W, 4, sideband tag width, passed through unchanged
- SAT, 1, 1 = saturate y to Y_W; 0 = wrap (keep low Y_W bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_x2  in  X2_W  signed operand
- in_a  in  A_W  signed constant coefficient
- in_b  in  B_W  signed linear coefficient
- in_c  in  C_W  signed quadratic coefficient
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  Y_W  signed result
- out_ovf  out  1  full-precision result fell outside the Y_W range (flag is independent of SAT)
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valid bits = 0; out_valid = 0, out_y = 0, out_ovf = 0, out_tag = 0. in_ready = 1 one cycle after rst deasserts. Datapath registers need no reset.
- Transfer rules:
  - A transfer occurs at a clk edge when valid && ready.
  - in_ready is combinational from downstream state.
  - out_valid/out_y/out_tag/out_ovf come from registers.
  - Once out_valid is high, out_y, out_ovf and out_tag hold until accepted.
- Pipeline:
  - S1 registers x2, a, b, c, tag and computes sq = x2*x2 (unsigned result, 2*X2_W bits).
  - S2 registers pb = b*x2 (B_W+X2_W bits) and pc = c*sq (C_W+2*X2_W+1 bits, sq zero-extended), and passes a and tag along.
  - S3 registers sum = a + pb + pc at full width SW = max(A_W, B_W+X2_W, C_W+2*X2_W+1)+2, then applies saturation or wrap.
- Latency and throughput: 3 cycles from input acceptance to out_valid with out_ready held high. Throughput is 1 sample/cycle.
- Flow control:
  - Each stage loads when it is empty or its contents move forward in the same cycle.
  - in_ready = !s1_valid || s1_advance.
  - No bubbles are inserted while out_ready = 1.
- Capacity: up to 3 samples in flight. With out_ready = 0, exactly 3 inputs are accepted, then in_ready = 0. Order is strictly preserved; no sample is dropped or duplicated.
- Simultaneous events: when the pipe is full and out_ready = 1 and in_valid = 1 in the same cycle, the block accepts the new input and retires the oldest result in that cycle.
- Overflow and saturation:
  - out_ovf = 1 when sum > 2^(Y_W-1)-1 or sum < -2^(Y_W-1).
  - SAT=1: out_y is clamped to 2^(Y_W-1)-1 or -2^(Y_W-1).
  - SAT=0: out_y = sum[Y_W-1:0].
- Reset mid-operation: all in-flight samples are discarded immediately. out_valid falls asynchronously and no stale result appears after release.
- Boundary case x2 = -2^(X2_W-1): sq = 2^(2*X2_W-2) must be exact. This is why sq is treated as unsigned or widened by 1.

Decomposition:
- Package quadra_pipe_pkg holds:
  - a function computing SW from the parameters
  - the saturation function
  - typedefs for the stage payload structs (operands + tag)
- Sub-module pipe_square: a registered, parametrised signed square with a valid pass-through, used for S1.

Test Plan (X2_W=8, A_W=16, B_W=12, C_W=12, Y_W=16, SAT=1 unless noted):
- Basic: x2=3, a=100, b=5, c=2, out_ready=1 -> out_y=133, out_ovf=0, out_valid exactly 3 cycles after acceptance, tag echoed.
- Negative / corner: x2=-4, a=0, b=10, c=1 -> out_y=-24. Then x2=-128, a=0, b=0, c=1 -> out_y=16384.
- Saturation: x2=-128, a=32767, b=0, c=2047 -> out_y=32767, out_ovf=1. Same with c=-2048 -> out_y=-32768, out_ovf=1. With SAT=0, same inputs -> out_y = low 16 bits of the full sum, out_ovf=1.
- Backpressure: out_ready=0, offer 5 back-to-back samples -> exactly 3 accepted, then in_ready=0. Release out_ready -> all 5 results emerge in order, then 1/cycle with no loss.
- Streaming: 100 random samples, random in_valid/out_ready -> outputs match a reference model bit-exactly, in order, with tags matching.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid drops immediately. After release, in_ready=1 and no stale output appears.
